// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, iterative shift-add MUL, valid/ready on both sides.
// Define ALU_SLT_EN to enable code 0111 (signed set-less-than); otherwise 0111 is reported illegal.
module alu_exec_unit #(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      ctrl_signal_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o,
   output logic            illegal_o
);

   localparam int NSTEP = XLEN / MUL_STEP;
   localparam int CW    = $clog2(NSTEP + 1);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_SLT = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] res_q, a_q, b_q, acc_q;
   logic [XLEN-1:0] alu_res, pp, acc_nxt;
   logic            alu_ill;
   logic            zero_q, ill_q, valid_q;
   logic [CW-1:0]   cnt_q;
   logic            accept, is_mul, mul_done;

   assign is_mul   = (ctrl_signal_i == OP_MUL);
   assign accept   = valid_i && ready_o;
   assign mul_done = (state_q == S_MUL) && (cnt_q == CW'(1));

   // One MUL_STEP-wide slice of the multiplier per cycle
   always_comb begin
      pp = '0;
      for (int j = 0; j < MUL_STEP; j++)
         if (b_q[j]) pp = pp + (a_q << j);
   end
   assign acc_nxt = acc_q + pp;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (ctrl_signal_i)
         OP_AND: alu_res = op_a_i & op_b_i;
         OP_OR:  alu_res = op_a_i | op_b_i;
         OP_ADD: alu_res = op_a_i + op_b_i;
         OP_SUB: alu_res = op_a_i - op_b_i;
         OP_MUL: alu_res = '0;
`ifdef ALU_SLT_EN
         OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_d = state_q;
      if (flush_i) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE: begin
               if (accept && is_mul)          state_d = S_MUL;
               else if (accept)               state_d = S_IDLE;
               else if (valid_q && !ready_i)  state_d = S_HOLD;
            end
            S_MUL:  if (mul_done) state_d = S_IDLE;
            S_HOLD: if (ready_i)  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      ready_o = (state_q == S_IDLE) && (!valid_q || ready_i) && !flush_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_q   <= '0;
         zero_q  <= 1'b1;
         ill_q   <= 1'b0;
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else begin
         if (accept && is_mul) begin
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            acc_q   <= '0;
            cnt_q   <= CW'(NSTEP);
            valid_q <= 1'b0;
         end else if (accept) begin
            res_q   <= alu_res;
            zero_q  <= (alu_res == '0);
            ill_q   <= alu_ill;
            valid_q <= 1'b1;
         end else if (mul_done) begin
            res_q   <= acc_nxt;
            zero_q  <= (acc_nxt == '0);
            ill_q   <= 1'b0;
            valid_q <= 1'b1;
         end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end
         if (state_q == S_MUL) begin
            acc_q <= acc_nxt;
            a_q   <= a_q << MUL_STEP;
            b_q   <= b_q >> MUL_STEP;
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign valid_o   = valid_q;
   assign result_o  = res_q;
   assign zero_o    = zero_q;
   assign illegal_o = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table plus hand-written MUL/hold/flush/reset sequences.
module tb_alu_exec_unit;

   logic        clk_i = 1'b0;
   logic        rst_ni, valid_i, ready_o, flush_i, valid_o, ready_i, zero_o, illegal_o;
   logic [3:0]  ctrl_signal_i;
   logic [31:0] op_a_i, op_b_i, result_o;

   always #5 clk_i = ~clk_i;

   alu_exec_unit #(.XLEN(32), .MUL_STEP(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
      .ctrl_signal_i(ctrl_signal_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o),
      .illegal_o(illegal_o)
   );

   typedef struct {logic [31:0] res; logic ill;} exp_t;
   typedef struct {logic [3:0] code; logic [31:0] a; logic [31:0] b; exp_t e;} vec_t;

   exp_t sbq[$];
   vec_t vecs[9];
   int   checks = 0;
   int   failures = 0;
   exp_t enone = '{32'h0, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Drive one cycle; scoreboard handshakes on both sides, then advance past the edge
   task automatic tick(input logic v, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, input logic fl, input int exp_rdy, input exp_t e);
      exp_t got;
      valid_i = v; ctrl_signal_i = code; op_a_i = a; op_b_i = b; ready_i = rdy; flush_i = fl;
      #1;
      if (exp_rdy >= 0) chk("ready_o", 32'(ready_o), 32'(exp_rdy));
      if (!fl && valid_o && ready_i) begin
         if (sbq.size() == 0) chk("unexpected_valid", 32'(valid_o), 32'd0);
         else begin
            got = sbq.pop_front();
            chk("result", result_o, got.res);
            chk("zero", 32'(zero_o), 32'(got.res == 32'd0));
            chk("illegal", 32'(illegal_o), 32'(got.ill));
         end
      end
      if (fl) sbq.delete();
      if (v && ready_o) sbq.push_back(e);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input logic rdy, input int exp_rdy);
      tick(1'b0, 4'h0, $urandom, $urandom, rdy, 1'b0, exp_rdy, enone);
   endtask

   // Accept a MUL, count busy cycles until valid_o, then drain
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] req);
      int n = 0;
      tick(1'b1, 4'b0011, a, b, 1'b1, 1'b0, 1, '{req, 1'b0});
      while (!valid_o && n < 100) begin
         idle(1'b1, 0);
         n++;
      end
      chk("mul_latency", 32'(n), 32'd32);
      idle(1'b1, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra, rb;
      vecs[0] = '{4'b0110, 32'd5,        32'd5,        '{32'h0000_0000, 1'b0}};
      vecs[1] = '{4'b0000, 32'h0000_F0F0, 32'h0000_0F0F, '{32'h0000_0000, 1'b0}};
      vecs[2] = '{4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, '{32'h0000_FFFF, 1'b0}};
      vecs[3] = '{4'b0010, 32'hFFFF_FFFF, 32'd1,        '{32'h0000_0000, 1'b0}};
      vecs[4] = '{4'b0110, 32'd0,        32'd1,        '{32'hFFFF_FFFF, 1'b0}};
`ifdef ALU_SLT_EN
      vecs[5] = '{4'b0111, 32'hFFFF_FFFF, 32'd1,        '{32'h0000_0001, 1'b0}};
      vecs[6] = '{4'b0111, 32'd1,        32'hFFFF_FFFF, '{32'h0000_0000, 1'b0}};
`else
      vecs[5] = '{4'b0111, 32'hFFFF_FFFF, 32'd1,        '{32'h0000_0000, 1'b1}};
      vecs[6] = '{4'b0111, 32'd1,        32'hFFFF_FFFF, '{32'h0000_0000, 1'b1}};
`endif
      vecs[7] = '{4'b1111, 32'd5,        32'd5,        '{32'h0000_0000, 1'b1}};
      vecs[8] = '{4'b0100, 32'd7,        32'd9,        '{32'h0000_0000, 1'b1}};

      rst_ni = 1'b0; valid_i = 1'b0; ctrl_signal_i = 4'h0; op_a_i = '0; op_b_i = '0;
      ready_i = 1'b1; flush_i = 1'b0;
      #12;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_zero", 32'(zero_o), 32'd1);
      chk("rst_illegal", 32'(illegal_o), 32'd0);
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("rst_ready", 32'(ready_o), 32'd1);

      // ADD overflow wrap, latency 1
      tick(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1, '{32'h8000_0000, 1'b0});
      chk("add_valid", 32'(valid_o), 32'd1);
      chk("add_result", result_o, 32'h8000_0000);
      chk("add_zero", 32'(zero_o), 32'd0);

      // Back-to-back single-cycle ops, ready_o must stay high
      for (int i = 0; i < 9; i++)
         tick(1'b1, vecs[i].code, vecs[i].a, vecs[i].b, 1'b1, 1'b0, 1, vecs[i].e);
      idle(1'b1, 1);
      chk("b2b_drained", 32'(valid_o), 32'd0);

      // MUL latency and results; operands toggle randomly while busy
      run_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
      run_mul(32'd0, 32'h0001_2345, 32'd0);
      for (int k = 0; k < 3; k++) begin
         ra = $urandom; rb = $urandom;
         run_mul(ra, rb, ra * rb);
      end

      // Result held for 4 cycles with ready_i low, then drained
      tick(1'b1, 4'b0010, 32'd2, 32'd3, 1'b0, 1'b0, 1, '{32'd5, 1'b0});
      for (int k = 0; k < 4; k++) begin
         chk("hold_valid", 32'(valid_o), 32'd1);
         chk("hold_result", result_o, 32'd5);
         tick(1'b1, 4'b0001, 32'd1, 32'd1, 1'b0, 1'b0, 0, enone);
      end
      idle(1'b1, -1);
      chk("hold_drained", 32'(valid_o), 32'd0);

      // Flush at MUL cycle 10, with a competing valid_i
      tick(1'b1, 4'b0011, 32'd7, 32'd9, 1'b1, 1'b0, 1, '{32'd63, 1'b0});
      repeat (9) idle(1'b1, 0);
      tick(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 1'b1, 0, enone);
      chk("flush_valid", 32'(valid_o), 32'd0);
      idle(1'b1, 1);
      repeat (40) idle(1'b1, -1);
      chk("flush_no_result", 32'(valid_o), 32'd0);

      // Reset mid-MUL
      tick(1'b1, 4'b0011, 32'd11, 32'd13, 1'b1, 1'b0, 1, '{32'd143, 1'b0});
      repeat (5) idle(1'b1, 0);
      #2 rst_ni = 1'b0;
      #1;
      sbq.delete();
      chk("midrst_valid", 32'(valid_o), 32'd0);
      chk("midrst_result", result_o, 32'd0);
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i); #1;
      idle(1'b1, 1);
      repeat (40) idle(1'b1, -1);
      chk("midrst_no_result", 32'(valid_o), 32'd0);

      // Post-reset sanity op
      tick(1'b1, 4'b0010, 32'd40, 32'd2, 1'b1, 1'b0, 1, '{32'd42, 1'b0});
      idle(1'b1, -1);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
